// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode constants and
// helpers that derive and validate the stage count from WIDTH and CHUNK.
package add_sub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Number of pipeline stages, one per CHUNK-bit slice.
  function automatic int stages_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // True when the operand width splits into whole slices.
  function automatic bit chunk_ok(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Stream interface of the pipelined adder/subtractor: operand beat in,
// result beat out, each side with its own valid/ready pair.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 16
) ();

  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;

  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;
  logic             Zero;

  // Producer / consumer side (drives operands, accepts results).
  modport master (
    output In_valid, A, B, Cin, Sub, Out_ready,
    input  In_ready, Out_valid, Sum, Carry, Overflow, Zero
  );

  // The adder itself.
  modport slave (
    input  In_valid, A, B, Cin, Sub, Out_ready,
    output In_ready, Out_valid, Sum, Carry, Overflow, Zero
  );

endinterface

// File: rtl/pipelined_add_sub_slice.sv
// Combinational CHUNK-bit adder for one pipeline stage. Besides the sum and
// carry out it reports the carry into its MSB, which the final stage needs
// for signed overflow.
module add_sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out directly.
  assign cmsb  = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor. The operands are split into
// CHUNK-bit slices; stage k adds slice k using the carry registered by stage
// k-1. The whole pipe stalls together when the last stage holds an unaccepted
// result, so In_ready depends only on Out_valid and Out_ready.
import add_sub_pkg::*;

module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_add_sub_if.slave  bus
);

  localparam int STAGES = stages_of(WIDTH, CHUNK);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a positive multiple of CHUNK");
  end

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              cin0;

  // Inputs seen by each stage: stage 0 from the bus, stage k from stage k-1.
  logic [WIDTH-1:0]  a_x [STAGES];
  logic [WIDTH-1:0]  b_x [STAGES];
  logic [WIDTH-1:0]  s_x [STAGES];
  logic [STAGES-1:0] c_x;
  logic [STAGES-1:0] v_x;

  // Per-stage valid bits; the last one is Out_valid.
  logic [STAGES-1:0] v_q;

  assign adv          = !v_q[STAGES-1] || bus.Out_ready;
  assign bus.In_ready = adv;
  assign bus.Out_valid = v_q[STAGES-1];

  // Subtraction is A + ~B + 1; the +1 rides in as the slice-0 carry.
  assign b_eff = (bus.Sub == SUB) ? ~bus.B : bus.B;
  assign cin0  = (bus.Sub == SUB) ? 1'b1 : bus.Cin;

  // Valid chain: bubbles shift through like beats, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_x[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] slice_sum;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] slice_wide;
    logic [WIDTH-1:0] s_nxt;

    if (k == 0) begin : g_first
      assign a_x[0] = bus.A;
      assign b_x[0] = b_eff;
      assign s_x[0] = '0;
      assign c_x[0] = cin0;
      assign v_x[0] = bus.In_valid;
    end

    add_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_x[k][k*CHUNK +: CHUNK]),
      .b    (b_x[k][k*CHUNK +: CHUNK]),
      .cin  (c_x[k]),
      .sum  (slice_sum),
      .cout (c_out),
      .cmsb (c_msb)
    );

    // Drop this slice into its position; earlier stages leave it zero.
    always_comb begin
      slice_wide = '0;
      slice_wide[k*CHUNK +: CHUNK] = slice_sum;
      s_nxt = s_x[k] | slice_wide;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] s_r;
      logic             c_r;

      // Intermediate stage data: no reset needed, qualified by the valid chain.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_r <= a_x[k];
          b_r <= b_x[k];
          s_r <= s_nxt;
          c_r <= c_out;
        end
      end

      assign a_x[k+1] = a_r;
      assign b_x[k+1] = b_r;
      assign s_x[k+1] = s_r;
      assign c_x[k+1] = c_r;
      assign v_x[k+1] = v_q[k];
    end else begin : g_last
      logic [WIDTH-1:0] s_r;
      logic             c_r;
      logic             ov_r;
      logic             z_r;
      logic             unused_ops;

      // Result registers: load only real beats so outputs never show bubble data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_r  <= '0;
          c_r  <= 1'b0;
          ov_r <= 1'b0;
          z_r  <= 1'b1;
        end else if (adv && v_x[k]) begin
          s_r  <= s_nxt;
          c_r  <= c_out;
          ov_r <= c_out ^ c_msb;
          z_r  <= (s_nxt == '0);
        end
      end

      // The last stage consumes only the top slice of the carried operands.
      assign unused_ops = ^{a_x[k], b_x[k]};

      assign bus.Sum      = s_r;
      assign bus.Carry    = c_r;
      assign bus.Overflow = ov_r;
      assign bus.Zero     = z_r;
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=16, CHUNK=4): directed literal cases,
// reset with beats in flight, and randomized streams under random
// backpressure, all scored against an arithmetic model.
module tb_pipelined_add_sub;

  localparam int W  = 16;
  localparam int ST = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ov;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   rand_ready = 1'b0;

  res_t exp_q[$];
  bit   stalled_prev = 1'b0;
  res_t held;

  pipelined_add_sub_if #(.WIDTH(W)) bus_if ();

  pipelined_add_sub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int ua, ub, sa, sb, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u = ua - ub;
      s = sa - sb;
      r.carry = (ua >= ub);
    end else begin
      u = ua + ub + int'(cin);
      s = sa + sb + int'(cin);
      r.carry = (u >= 65536);
    end
    r.sum  = u[W-1:0];
    r.ov   = (s > 32767) || (s < -32768);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.sum   = bus_if.Sum;
    r.carry = bus_if.Carry;
    r.ov    = bus_if.Overflow;
    r.zero  = bus_if.Zero;
    return r;
  endfunction

  // Scoreboard: sample half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stalled_prev = 1'b0;
    end else begin
      res_t got, want;
      got = dut_res();
      check("in_ready", {31'd0, bus_if.In_ready},
            {31'd0, !(bus_if.Out_valid && !bus_if.Out_ready)});
      if (stalled_prev) begin
        check("stall_valid", {31'd0, bus_if.Out_valid}, 32'd1);
        check("stall_hold", {12'd0, got}, {12'd0, held});
      end
      if (bus_if.Out_valid && bus_if.Out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {31'd0, bus_if.Out_valid}, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check("sum", {16'd0, got.sum}, {16'd0, want.sum});
          check("carry", {31'd0, got.carry}, {31'd0, want.carry});
          check("overflow", {31'd0, got.ov}, {31'd0, want.ov});
          check("zero", {31'd0, got.zero}, {31'd0, want.zero});
        end
      end
      stalled_prev = bus_if.Out_valid && !bus_if.Out_ready;
      held = got;
      if (bus_if.In_valid && bus_if.In_ready)
        exp_q.push_back(model(bus_if.A, bus_if.B, bus_if.Cin, bus_if.Sub));
    end
  end

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) bus_if.Out_ready = 1'($urandom_range(1));
  end

  // Present one beat (starting at posedge+1) and hold it until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    bit took;
    int guard;
    bus_if.In_valid = 1'b1;
    bus_if.A = a;
    bus_if.B = b;
    bus_if.Cin = cin;
    bus_if.Sub = sub;
    took = 1'b0;
    guard = 0;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = bus_if.In_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!took) check("accept_timeout", 32'd0, 32'd1);
    bus_if.In_valid = 1'b0;
  endtask

  // Directed beat with literal expectations and latency check (Out_ready=1).
  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] esum,
                          input logic ecarry, input logic eov, input logic ezero);
    int lat;
    send(a, b, cin, sub);
    lat = 1;
    @(negedge clk);
    while (!bus_if.Out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, ST);
    check({name, "_sum"}, {16'd0, bus_if.Sum}, {16'd0, esum});
    check({name, "_carry"}, {31'd0, bus_if.Carry}, {31'd0, ecarry});
    check({name, "_ovf"}, {31'd0, bus_if.Overflow}, {31'd0, eov});
    check({name, "_zero"}, {31'd0, bus_if.Zero}, {31'd0, ezero});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(5))
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'h8000;
      3: v = 16'h7FFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic stream(input int n, input int bubble_pct);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < bubble_pct) begin
        bus_if.In_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(pick_operand(), pick_operand(), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask

  task automatic drain();
    int guard;
    rand_ready = 1'b0;
    bus_if.Out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || bus_if.Out_valid) && guard < 100) begin
      @(posedge clk);
      #1;
      bus_if.Out_ready = 1'b1;
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus_if.In_valid = 1'b0;
    bus_if.A = '0;
    bus_if.B = '0;
    bus_if.Cin = 1'b0;
    bus_if.Sub = 1'b0;
    bus_if.Out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus_if.Out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus_if.In_ready}, 32'd1);
    check("rst_sum", {16'd0, bus_if.Sum}, 32'd0);
    check("rst_carry", {31'd0, bus_if.Carry}, 32'd0);
    check("rst_ovf", {31'd0, bus_if.Overflow}, 32'd0);
    check("rst_zero", {31'd0, bus_if.Zero}, 32'd1);
    @(posedge clk);
    #1;

    directed("add",    16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0, 1'b0);
    directed("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("allone", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    directed("aminusa", 16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Three beats in flight, then an asynchronous reset between edges.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0);
    send(16'h5555, 16'h0001, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus_if.Out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postrst_no_beat", {31'd0, bus_if.Out_valid}, 32'd0);
      check("postrst_zero", {31'd0, bus_if.Zero}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Back-to-back beats under random backpressure, then a longer mixed run.
    rand_ready = 1'b1;
    stream(8, 0);
    drain();
    rand_ready = 1'b1;
    stream(300, 30);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream handshake. It is the next generation of the team's 16-bit chained adder. The operand width is split into CHUNK-bit slices, and each slice is added in its own pipeline stage. The carry between slices is registered, so the clock rate is set by one CHUNK-bit add instead of the full WIDTH ripple. It sits between operand-producing datapath logic and any consumer that may stall.

## Interface
- WIDTH, 16: operand and Sum width in bits. Must be ≥ 1 and a multiple of CHUNK.
- CHUNK, 4: bits added per pipeline stage. STAGES = WIDTH/CHUNK.
- clk  input  1  rising-edge clock. This is the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- In_valid  input  1  operand beat present.
- In_ready  output  1  block accepts a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in. Ignored when Sub=1.
- Sub  input  1  0: A+B+Cin. 1: A−B (A + ~B + 1).
- Out_valid  output  1  result beat present.
- Out_ready  input  1  consumer accepts the result.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Carry  output  1  carry out of the MSB. When Sub=1, Carry=1 means no borrow (A ≥ B unsigned).
- Overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- Zero  output  1  Sum == 0.

## Operation
- Accept: a beat is taken when In_valid && In_ready.
- Stage 0 handles slice 0 with these inputs:
  - A[CHUNK-1:0].
  - B slice, inverted if Sub=1.
  - Carry-in = Sub ? 1 : Cin.
- Stage 0 registers:
  - slice-0 sum and carry out;
  - the remaining A and B-effective slices;
  - the valid bit.
- Stage k adds slice k using the registered carry from stage k−1. It passes forward:
  - the completed low slices;
  - the pending high slices;
  - the carry;
  - the valid bit.
- The final stage also registers the carry into its MSB, which is used to compute Overflow.
- Each stage holds its own valid bit. Stage registers update only when the pipeline advances.
- Advance: adv = !Out_valid || Out_ready. The whole pipeline shifts together (global stall).
- In_ready = adv. This is combinational from Out_valid and Out_ready; there is no path from In_valid.
- A bubble (In_valid=0 when adv=1) enters the pipeline as valid=0. Bubbles are not collapsed.
- Sum, Carry, Overflow and Zero are registered outputs of the last stage. They are held stable while Out_valid && !Out_ready.
- Data registers need no reset. All valid bits reset to 0.

## Timing
- Reset values:
  - Out_valid=0.
  - Sum=0, Carry=0, Overflow=0, Zero=1 (outputs cleared at reset).
  - In_ready=1 once rst_n is high, because Out_valid=0.
- Latency: a beat accepted at edge N appears with Out_valid=1 after edge N+STAGES−1. With STAGES=1, the result is visible the cycle after acceptance.
- Throughput: one beat per cycle while Out_ready=1.
- Stall: while Out_valid && !Out_ready, In_ready=0 and no register changes.
- Simultaneous events: Out_ready=1 and In_valid=1 in the same cycle means the output pops and a new beat is accepted at the same edge.
- Reset mid-operation: every in-flight beat is discarded and valids clear immediately (asynchronous). No partial result is ever presented.
- Boundaries:
  - A=B=2^WIDTH−1 with Cin=1 gives Sum=2^WIDTH−1, Carry=1.
  - A−A gives Sum=0, Carry=1, Zero=1.
  - CHUNK=WIDTH degenerates to a single registered stage.

## Structure
- Shared package add_sub_pkg holds:
  - the ADD=1'b0 and SUB=1'b1 mode constants;
  - a function returning STAGES from WIDTH and CHUNK;
  - an elaboration check that WIDTH % CHUNK == 0.
- Sub-module add_sub_slice: combinational CHUNK-bit adder producing sum, carry out, and carry into its MSB. It is instantiated once per stage with a generate loop.

## Test plan
- Reset: assert rst_n=0 mid-stream with 3 beats in flight, then release. Required: Out_valid=0 and Zero=1, with no stale beat emitted.
- Add stream (WIDTH=16, CHUNK=4, latency 4): send 0x1234+0x0FCD with Cin=1. Required: Sum=0x2202, Carry=0, Overflow=0.
- Wrap and carry: send 0xFFFF+0x0001 with Cin=0. Required: Sum=0x0000, Carry=1, Zero=1, Overflow=0.
- Subtract and overflow: send 0x8000−0x0001 with Sub=1. Required: Sum=0x7FFF, Carry=1, Overflow=1.
- Subtract with borrow: send 0x0003−0x0005. Required: Sum=0xFFFE, Carry=0.
- Backpressure: 8 back-to-back beats with Out_ready toggling randomly. Required:
  - results match the reference model in order, with none dropped or duplicated;
  - outputs are stable whenever stalled;
  - In_ready=0 exactly when Out_valid && !Out_ready.
